motion_diff_ctrl: RTL and testbench
===================================

# motion_diff_ctrl

Frame-difference scheduler for the image-processing pipeline. On `start` it sweeps every pixel address of two RGB332 frame buffers, the current frame and the reference frame. Each pixel pair goes through the pixel-difference datapath (`euclid_px_diff`, instantiated inside this block), and each result is compared against a threshold. The block writes a 1-bit change mask, counts changed pixels and, once per frame, reports a motion flag to the downstream display/overlay logic.

## Interface
- `ADDR_W`, 17, width of the pixel address (fits 320x240).
- `NUM_PX`, 76800, pixels per frame; sweep covers addresses 0..NUM_PX-1.
- `CNT_W`, 17, width of the changed-pixel counter and `min_count`.
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: start request; sampled only in IDLE.
- `thresh` in 8: difference threshold; latched on accepted `start`.
- `min_count` in CNT_W: changed-pixel count needed for motion; latched on accepted `start`.
- `rd_en` out 1: read strobe to both frame buffers.
- `rd_addr` out ADDR_W: shared read address for both buffers.
- `px_cur` in 8: current-frame pixel, valid 1 cycle after `rd_en`.
- `px_ref` in 8: reference-frame pixel, valid 1 cycle after `rd_en`.
- `mask_we` out 1: change-mask write strobe.
- `mask_addr` out ADDR_W: change-mask address.
- `mask_bit` out 1: 1 = pixel changed.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle pulse at the end of the frame.
- `changed_count` out CNT_W: changed pixels in the last frame; held until the next accepted `start`.
- `motion` out 1: `changed_count >= min_count` for the last frame; held.

## Operation
- Difference function: the pixel is split as R=[7:5], G=[4:2], B=[1:0].
  - diff = |R1-R2| + |G1-G2| + 2*|B1-B2|.
  - Range 0..20, carried on 8 bits with no overflow.
- A pixel is changed iff diff > `thresh` (strictly greater). `thresh`=255 means no pixel can be changed.
- States:
  - IDLE: outputs idle. On `start` = 1, latch `thresh` and `min_count`, clear the internal counter and go to RUN.
  - RUN: issue one read per cycle, addresses 0..NUM_PX-1 in order. After issuing address NUM_PX-1, go to DRAIN.
  - DRAIN: retire the 2 in-flight pipeline stages, then go to DONE.
  - DONE: register `changed_count` and `motion`, pulse `done` and return to IDLE.
- Pipeline has 3 stages:
  - Stage 0: address issue.
  - Stage 1: buffer read.
  - Stage 2: registered diff, compare, mask write and counter increment.
- `start` asserted in RUN, DRAIN or DONE is ignored and is not queued.
- The counter cannot overflow because NUM_PX < 2^CNT_W; no saturation logic.
- `min_count` = 0 gives `motion` = 1 for every frame.
- `changed_count` and `motion` update only in DONE. Intermediate counts are never visible on the outputs.

## Timing
- Reset values of all outputs are 0: `rd_en`, `rd_addr`, `mask_we`, `mask_addr`, `mask_bit`, `busy`, `done`, `changed_count`, `motion`. State returns to IDLE.
- Take `start` sampled high in IDLE at rising edge k:
  - `rd_en`=1 with `rd_addr`=i in cycle k+1+i, for i = 0..NUM_PX-1. `rd_en` is 0 otherwise.
  - `px_cur`/`px_ref` for address i are sampled at the end of cycle k+2+i.
  - `mask_we`=1 with `mask_addr`=i in cycle k+3+i; counter updates at the end of that cycle.
  - `busy`=1 in cycles k+1 .. k+2+NUM_PX.
  - `done`=1 in cycle k+3+NUM_PX, with the final `changed_count`/`motion` valid from that cycle on.
- Back-to-back frames: the next `start` is accepted no earlier than cycle k+4+NUM_PX. Frame period is NUM_PX+4 cycles.
- Reset mid-sweep takes effect immediately (asynchronous):
  - No further `mask_we` or `rd_en`.
  - `changed_count`/`motion` are cleared to 0.
  - The partial frame is discarded and no `done` is produced.
- `thresh`/`min_count` changes during a sweep have no effect on the current frame.

## Test plan
- NUM_PX=8, both frames all 0x5A, `thresh`=0, `min_count`=1 -> 8 mask writes of 0, `changed_count`=0, `motion`=0, `done` exactly at k+11.
- `px_cur`=0xFF, `px_ref`=0x00 for all pixels, `thresh`=19 -> every pixel diff = 20, `mask_bit`=1 ×8, `changed_count`=8, `motion`=1 with `min_count`=8.
- Weighting/boundary, `thresh`=5:
  - pixel pair (0x03, 0x00): diff 6 -> `mask_bit`=1.
  - pixel pair (0x01, 0x02): diff 2 -> 0.
  - pixel pair (0xA0, 0x00): diff 5 -> 0, equal to `thresh` so not counted.
  - Check `changed_count`=1.
- Pulse `start` at cycles k+3 and k+11 (during busy and during done) -> ignored. Exactly 8 reads, one `done`, `rd_addr` sequence 0..7 uninterrupted.
- Assert `rst` for 1 cycle at k+5 -> all outputs 0 asynchronously, no `done`. A fresh `start` then produces a complete, correct frame.
- `min_count`=0 with identical frames -> `changed_count`=0, `motion`=1. Then change `min_count` mid-sweep to 9 -> result unaffected.

Source files
------------

// File: rtl/motion_diff_if.sv
// Bus bundle between the frame-difference controller and its frame buffers,
// change-mask memory and display/overlay consumers.
interface motion_diff_if #(
  parameter int ADDR_W = 17,
  parameter int CNT_W  = 17
);
  logic              start;
  logic [7:0]        thresh;
  logic [CNT_W-1:0]  min_count;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        px_cur;
  logic [7:0]        px_ref;
  logic              mask_we;
  logic [ADDR_W-1:0] mask_addr;
  logic              mask_bit;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  changed_count;
  logic              motion;

  modport master (
    input  start, thresh, min_count, px_cur, px_ref,
    output rd_en, rd_addr, mask_we, mask_addr, mask_bit, busy, done,
           changed_count, motion
  );

  modport slave (
    output start, thresh, min_count, px_cur, px_ref,
    input  rd_en, rd_addr, mask_we, mask_addr, mask_bit, busy, done,
           changed_count, motion
  );
endinterface

// File: rtl/motion_diff_ctrl.sv
// Frame-difference scheduler: sweeps two RGB332 buffers, writes a change mask,
// counts changed pixels and reports a per-frame motion flag.
module euclid_px_diff (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] diff_o
);
  logic [2:0] dr;
  logic [2:0] dg;
  logic [1:0] db;

  // Blue has one bit less resolution, so it is weighted x2.
  always_comb begin
    dr = (a_i[7:5] >= b_i[7:5]) ? a_i[7:5] - b_i[7:5] : b_i[7:5] - a_i[7:5];
    dg = (a_i[4:2] >= b_i[4:2]) ? a_i[4:2] - b_i[4:2] : b_i[4:2] - a_i[4:2];
    db = (a_i[1:0] >= b_i[1:0]) ? a_i[1:0] - b_i[1:0] : b_i[1:0] - a_i[1:0];
    diff_o = {5'd0, dr} + {5'd0, dg} + {5'd0, db, 1'b0};
  end
endmodule

module motion_diff_ctrl #(
  parameter int ADDR_W = 17,
  parameter int NUM_PX = 76800,
  parameter int CNT_W  = 17
) (
  input  logic          clk,
  input  logic          rst,
  motion_diff_if.master bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PX - 1);

  logic [1:0]        state_q, state_d;
  logic [7:0]        thresh_q;
  logic [CNT_W-1:0]  min_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              s1_valid_q;
  logic [ADDR_W-1:0] s1_addr_q;
  logic              mask_we_q;
  logic [ADDR_W-1:0] mask_addr_q;
  logic              mask_bit_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              drain_q;
  logic              busy_q;
  logic              done_q;
  logic [CNT_W-1:0]  changed_q;
  logic              motion_q;
  logic [7:0]        diff;

  euclid_px_diff u_diff (
    .a_i    (bus.px_cur),
    .b_i    (bus.px_ref),
    .diff_o (diff)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (rd_addr_q == LAST_ADDR) state_d = S_DRAIN;
      S_DRAIN: if (drain_q) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    // Includes the write retiring this cycle so DONE sees the final pixel.
    cnt_d = cnt_q + CNT_W'(mask_we_q & mask_bit_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      thresh_q    <= '0;
      min_q       <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      mask_we_q   <= 1'b0;
      mask_addr_q <= '0;
      mask_bit_q  <= 1'b0;
      cnt_q       <= '0;
      drain_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      changed_q   <= '0;
      motion_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_valid_q  <= rd_en_q;
      s1_addr_q   <= rd_addr_q;
      mask_we_q   <= s1_valid_q;
      mask_addr_q <= s1_addr_q;
      mask_bit_q  <= s1_valid_q && (diff > thresh_q);
      cnt_q       <= cnt_d;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            thresh_q  <= bus.thresh;
            min_q     <= bus.min_count;
            cnt_q     <= '0;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
            busy_q    <= 1'b1;
            drain_q   <= 1'b0;
          end
        end
        S_RUN: begin
          if (rd_addr_q == LAST_ADDR) rd_en_q <= 1'b0;
          else                        rd_addr_q <= rd_addr_q + ADDR_W'(1);
        end
        S_DRAIN: begin
          drain_q <= 1'b1;
          if (drain_q) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            changed_q <= cnt_d;
            motion_q  <= (cnt_d >= min_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rd_en         = rd_en_q;
  assign bus.rd_addr       = rd_addr_q;
  assign bus.mask_we       = mask_we_q;
  assign bus.mask_addr     = mask_addr_q;
  assign bus.mask_bit      = mask_bit_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.changed_count = changed_q;
  assign bus.motion        = motion_q;
endmodule

// File: tb/tb_motion_diff_ctrl.sv
// Scoreboard bench for motion_diff_ctrl with an 8-pixel frame: stimulus queues
// expected mask writes and frame results, a negedge monitor retires them.
module tb_motion_diff_ctrl;
  localparam int N  = 8;
  localparam int AW = 17;
  localparam int CW = 17;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  motion_diff_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

  motion_diff_ctrl #(.ADDR_W(AW), .NUM_PX(N), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {int unsigned addr; int unsigned bitv; int unsigned cyc;} mask_exp_t;
  typedef struct {int unsigned cnt; int unsigned mot; int unsigned cyc;} done_exp_t;

  mask_exp_t   mask_q[$];
  done_exp_t   done_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned k_cur = 0;
  int unsigned rd_cnt = 0;
  int unsigned frames_done = 0;
  bit          frame_active = 1'b0;
  logic [7:0]  cur_mem [N];
  logic [7:0]  ref_mem [N];

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read frame buffers: data valid the cycle after rd_en.
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.px_cur <= cur_mem[bus.rd_addr[2:0]];
      bus.px_ref <= ref_mem[bus.rd_addr[2:0]];
    end
  end

  function automatic void chk(string name, int unsigned act, int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic void flag(string name);
    checks++;
    errors++;
    $display("FAIL %s: got an event, expected none", name);
  endfunction

  always @(negedge clk) begin
    mask_exp_t m;
    done_exp_t d;
    if (!rst) begin
      if (bus.rd_en) begin
        if (!frame_active) flag("rd_en_outside_frame");
        else begin
          chk("rd_addr", 32'(bus.rd_addr), rd_cnt);
          chk("rd_cycle", cyc, k_cur + rd_cnt);
          rd_cnt++;
        end
      end
      if (bus.mask_we) begin
        if (mask_q.size() == 0) flag("unexpected_mask_we");
        else begin
          m = mask_q.pop_front();
          $display("mask write addr %0d bit %0d cyc %0d", bus.mask_addr, bus.mask_bit, cyc);
          chk("mask_addr", 32'(bus.mask_addr), m.addr);
          chk("mask_bit", 32'(bus.mask_bit), m.bitv);
          chk("mask_cycle", cyc, m.cyc);
        end
      end
      if (bus.done) begin
        frames_done++;
        if (done_q.size() == 0) flag("unexpected_done");
        else begin
          d = done_q.pop_front();
          $display("frame done count %0d motion %0d cyc %0d", bus.changed_count, bus.motion, cyc);
          chk("changed_count", 32'(bus.changed_count), d.cnt);
          chk("motion", 32'(bus.motion), d.mot);
          chk("done_cycle", cyc, d.cyc);
        end
      end
    end
  end

  // mode 0: plain frame; 1: extra start pulses while busy and in DONE;
  // 2: thresh/min_count changed mid-sweep.
  task automatic run_frame(input logic [7:0] th, input logic [CW-1:0] mc,
                           input logic [N-1:0] exp_mask, input int unsigned exp_cnt,
                           input bit exp_mot, input int mode);
    int unsigned k;
    int unsigned fd0;
    @(negedge clk);
    bus.thresh    = th;
    bus.min_count = mc;
    bus.start     = 1'b1;
    rd_cnt        = 0;
    frame_active  = 1'b1;
    fd0           = frames_done;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    k         = cyc;
    k_cur     = k;
    for (int unsigned i = 0; i < N; i++)
      mask_q.push_back('{addr: i, bitv: 32'(exp_mask[i]), cyc: k + 2 + i});
    // done is visible in the cycle after edge k+N+2 (cycle k+3+NUM_PX).
    done_q.push_back('{cnt: exp_cnt, mot: 32'(exp_mot), cyc: k + N + 2});
    while (cyc < k + N + 3) begin
      @(negedge clk);
      chk("busy", 32'(bus.busy), 32'(cyc >= k && cyc <= k + N + 1));
      if (mode == 1) bus.start = (cyc == k + 2) || (cyc == k + N + 2);
      if (mode == 2 && cyc == k + 3) begin
        bus.min_count = 9;
        bus.thresh    = 8'd0;
      end
    end
    frame_active = 1'b0;
    chk("reads_per_frame", rd_cnt, N);
    chk("dones_per_frame", frames_done - fd0, 1);
    chk("changed_count_held", 32'(bus.changed_count), exp_cnt);
    chk("motion_held", 32'(bus.motion), 32'(exp_mot));
  endtask

  task automatic check_all_zero(input string tag);
    $display("output check %s", tag);
    chk("zero_rd_en", 32'(bus.rd_en), 0);
    chk("zero_rd_addr", 32'(bus.rd_addr), 0);
    chk("zero_mask_we", 32'(bus.mask_we), 0);
    chk("zero_mask_addr", 32'(bus.mask_addr), 0);
    chk("zero_mask_bit", 32'(bus.mask_bit), 0);
    chk("zero_busy", 32'(bus.busy), 0);
    chk("zero_done", 32'(bus.done), 0);
    chk("zero_changed_count", 32'(bus.changed_count), 0);
    chk("zero_motion", 32'(bus.motion), 0);
  endtask

  task automatic fill(input logic [7:0] c, input logic [7:0] r);
    for (int i = 0; i < N; i++) begin
      cur_mem[i] = c;
      ref_mem[i] = r;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000 ns");
    $fatal(1);
  end

  initial begin
    int unsigned k;
    int unsigned fd0;
    bus.start     = 1'b0;
    bus.thresh    = 8'd0;
    bus.min_count = '0;
    #1 rst = 1'b1;
    #2 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Identical frames: nothing changes, 1 needed for motion.
    fill(8'h5A, 8'h5A);
    run_frame(8'd0, 17'd1, 8'h00, 0, 1'b0, 0);

    // Maximal difference (20) just above thresh 19.
    fill(8'hFF, 8'h00);
    run_frame(8'd19, 17'd8, 8'hFF, 8, 1'b1, 0);

    // Asynchronous reset in cycle k+5 of a sweep.
    @(negedge clk);
    bus.thresh    = 8'd19;
    bus.min_count = 17'd8;
    bus.start     = 1'b1;
    rd_cnt        = 0;
    frame_active  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    k         = cyc;
    k_cur     = k;
    for (int unsigned i = 0; i < N; i++)
      mask_q.push_back('{addr: i, bitv: 1, cyc: k + 2 + i});
    while (cyc < k + 4) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("mid-sweep reset");
    mask_q.delete();
    frame_active = 1'b0;
    fd0          = frames_done;
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (16) @(negedge clk);
    chk("no_done_after_reset", frames_done - fd0, 0);

    // Fresh frame after reset.
    run_frame(8'd19, 17'd8, 8'hFF, 8, 1'b1, 0);

    // Channel weighting and the diff == thresh boundary.
    fill(8'h37, 8'h37);
    cur_mem[0] = 8'h03; ref_mem[0] = 8'h00;
    cur_mem[1] = 8'h01; ref_mem[1] = 8'h02;
    cur_mem[2] = 8'hA0; ref_mem[2] = 8'h00;
    run_frame(8'd5, 17'd2, 8'h01, 1, 1'b0, 0);

    // thresh 255 masks everything; stray start pulses are ignored.
    fill(8'hFF, 8'h00);
    run_frame(8'd255, 17'd1, 8'h00, 0, 1'b0, 1);

    // min_count 0 forces motion; mid-sweep parameter changes are ignored.
    for (int i = 0; i < N; i++) begin
      cur_mem[i] = 8'(i * 37);
      ref_mem[i] = 8'(i * 37);
    end
    run_frame(8'd0, 17'd0, 8'h00, 0, 1'b1, 2);

    repeat (3) @(negedge clk);
    chk("mask_queue_drained", mask_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
